// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and shared-bus arbiter between the CPU and the DMA engine.
// Define DMA_READBACK_EN to make CPU reads of 0xFF46 return the latched source page.
module oam_dma_controller #(
    parameter int BYTE_CLKS = 4,
    parameter int DMA_LEN   = 160
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_wr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active,
    output logic        cpu_blocked
);

    localparam int PW = $clog2(BYTE_CLKS);
    localparam logic [PW-1:0] LAST_PH  = PW'(BYTE_CLKS - 1);
    localparam logic [7:0]    LAST_IDX = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state, state_n;
    logic [7:0]    src, src_n;
    logic [7:0]    idx, idx_n;
    logic [PW-1:0] phase, phase_n;
    logic          blocked;
    logic          trigger;
    logic          cpu_low;
    logic          xfer;

    assign trigger = cpu_wr && (cpu_addr == 16'hFF46);
    assign cpu_low = cpu_addr < 16'hFF00;
    assign xfer    = state == XFER;

    always_ff @(posedge cpu_clk) begin
        if (!rst) begin
            state   <= IDLE;
            src     <= 8'h00;
            idx     <= 8'h00;
            phase   <= '0;
            blocked <= 1'b0;
        end else begin
            state   <= state_n;
            src     <= src_n;
            idx     <= idx_n;
            phase   <= phase_n;
            blocked <= xfer && (cpu_rd || cpu_wr) && cpu_low;
        end
    end

    // A trigger wins over every state transition, including the final byte.
    always_comb begin
        state_n = state;
        src_n   = src;
        idx_n   = idx;
        phase_n = phase;
        if (trigger) begin
            state_n = START;
            src_n   = cpu_wdata;
            idx_n   = 8'h00;
            phase_n = '0;
        end else begin
            unique case (state)
                IDLE: ;
                START: begin
                    if (phase == LAST_PH) begin
                        state_n = XFER;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                XFER: begin
                    if (phase == LAST_PH) begin
                        phase_n = '0;
                        if (idx == LAST_IDX) state_n = IDLE;
                        else idx_n = idx + 8'd1;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_rd    = cpu_rd && cpu_low;
        mem_wr    = cpu_wr && cpu_low;
        mem_wdata = cpu_wdata;
        oam_addr  = idx;
        oam_wdata = mem_rdata;
        oam_wr    = 1'b0;
        cpu_rdata = mem_rdata;
        if (xfer) begin
            mem_addr  = {src, idx};
            mem_rd    = phase == '0;
            mem_wr    = 1'b0;
            mem_wdata = 8'h00;
            oam_wr    = phase == PW'(1);
            if (cpu_low) cpu_rdata = 8'hFF;
        end
        if (cpu_addr == 16'hFF46) begin
`ifdef DMA_READBACK_EN
            cpu_rdata = src;
`else
            cpu_rdata = 8'hFF;
`endif
        end
    end

    assign dma_active  = xfer;
    assign cpu_blocked = blocked;

endmodule
